load_store_unit: RTL and testbench

//   Sits between the execute stage and data_memory. Accepts one load/store request at a time,

---
 rtl/load_store_unit.sv | 177 +++++++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Brief    : Single-outstanding load/store unit between execute and
//            data_memory. Checks funct3/alignment/range, drives sub-word
//            writes, absorbs the 1-cycle synchronous read latency and
//            sign/zero-extends load data. One response per request over a
//            valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int AW = 11,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  // request channel
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [2:0]    req_funct3_i,
  input  logic [31:0]   req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  // response channel
  output logic          resp_valid_o,
  input  logic          resp_ready_i,
  output logic [DW-1:0] resp_rdata_o,
  output logic [1:0]    resp_err_o,
  // data_memory interface
  output logic          mem_wr_o,
  output logic [2:0]    mem_size_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam logic [1:0] C_ERR_NONE     = 2'b00;
  localparam logic [1:0] C_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] C_ERR_RANGE    = 2'b10;
  localparam logic [1:0] C_ERR_FUNCT3   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_WAIT = 2'd1,
    S_RESP      = 2'd2
  } state_t;

  state_t         state_q;
  logic           resp_valid_q;
  logic [DW-1:0]  resp_rdata_q;
  logic [1:0]     resp_err_q;
  logic [AW-1:0]  addr_q;
  logic [2:0]     size_q;
  logic [DW-1:0]  wdata_q;
  logic [2:0]     f3_q;

  logic           accept;
  logic           f3_legal;
  logic           misaligned;
  logic           out_of_range;
  logic [1:0]     err_d;
  logic [2:0]     size_d;
  logic [DW-1:0]  wdata_d;
  logic [DW-1:0]  ld_data_d;

  assign req_ready_o  = (state_q == S_IDLE);
  assign accept       = req_valid_i & req_ready_o;

  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

  // Classify the presented request; fault codes are priority ordered.
  always_comb begin
    f3_legal     = 1'b0;
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    err_d        = C_ERR_NONE;
    case (req_funct3_i)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~req_we_i;   // unsigned forms are load-only
      default:                f3_legal = 1'b0;
    endcase
    misaligned   = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                   ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    out_of_range = |req_addr_i[31:AW];
    if (!f3_legal)         err_d = C_ERR_FUNCT3;
    else if (misaligned)   err_d = C_ERR_MISALIGN;
    else if (out_of_range) err_d = C_ERR_RANGE;
    else                   err_d = C_ERR_NONE;
  end

  // Size code and lane-masked store data derived from the presented request.
  always_comb begin
    size_d  = {1'b0, req_funct3_i[1:0]};
    wdata_d = req_wdata_i;
    case (req_funct3_i[1:0])
      2'b00:   wdata_d = {24'd0, req_wdata_i[7:0]};
      2'b01:   wdata_d = {16'd0, req_wdata_i[15:0]};
      default: wdata_d = req_wdata_i;
    endcase
  end

  // Memory side: live from the request while idle, frozen from capture otherwise.
  always_comb begin
    mem_wr_o    = accept & req_we_i & (err_d == C_ERR_NONE);
    mem_size_o  = (state_q == S_IDLE) ? size_d                  : size_q;
    mem_addr_o  = (state_q == S_IDLE) ? req_addr_i[AW-1:0]      : addr_q;
    mem_wdata_o = (state_q == S_IDLE) ? wdata_d                 : wdata_q;
  end

  // Extend returned load data; memory already places sub-words in low lanes.
  always_comb begin
    ld_data_d = mem_rdata_i;
    case (f3_q)
      3'b000:  ld_data_d = {{24{mem_rdata_i[7]}},  mem_rdata_i[7:0]};
      3'b100:  ld_data_d = {24'd0,                 mem_rdata_i[7:0]};
      3'b001:  ld_data_d = {{16{mem_rdata_i[15]}}, mem_rdata_i[15:0]};
      3'b101:  ld_data_d = {16'd0,                 mem_rdata_i[15:0]};
      default: ld_data_d = mem_rdata_i;
    endcase
  end

  // Request/response FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= C_ERR_NONE;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      f3_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q       <= req_addr_i[AW-1:0];
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            f3_q         <= req_funct3_i;
            resp_rdata_q <= '0;
            resp_err_q   <= err_d;
            if ((err_d == C_ERR_NONE) && !req_we_i) begin
              // clean load: wait for the synchronous read data
              state_q <= S_LOAD_WAIT;
            end else begin
              // store ack or fault: answer next cycle
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
            end
          end
        end
        S_LOAD_WAIT: begin
          resp_rdata_q <= ld_data_d;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Directed self-checking bench for load_store_unit with a small
//            byte-addressed synchronous data_memory model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic [1:0]    resp_err;
  logic          mem_wr;
  logic [2:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  load_store_unit #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .mem_wr_o     (mem_wr),
    .mem_size_o   (mem_size),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_memory model: byte array, sub-word writes, 1-cycle synchronous read
  logic [7:0] mem [2**AW];
  logic [AW-1:0] a1, a2, a3;
  assign a1 = mem_addr + 11'd1;
  assign a2 = mem_addr + 11'd2;
  assign a3 = mem_addr + 11'd3;

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    mem_rdata <= {mem[a3], mem[a2], mem[a1], mem[mem_addr]};
    if (mem_wr) begin
      mem[mem_addr] <= mem_wdata[7:0];
      if (mem_size != 3'b000) mem[a1] <= mem_wdata[15:8];
      if (mem_size == 3'b010) begin
        mem[a2] <= mem_wdata[23:16];
        mem[a3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request, check the accept cycle, wait for and take the response.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] eerr, input logic [31:0] erd);
    int   lat;
    int   elat;
    logic ewr;
    ewr  = we && (eerr == 2'b00);
    elat = (!we && (eerr == 2'b00)) ? 2 : 1;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    #1;
    chk({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, " mem_wr"},    {31'd0, mem_wr},    {31'd0, ewr});
    chk({tag, " mem_addr"},  {21'd0, mem_addr},  {21'd0, addr[AW-1:0]});
    if (ewr) begin
      chk({tag, " mem_size"},  {29'd0, mem_size}, {29'd0, 1'b0, f3[1:0]});
      chk({tag, " mem_wdata"}, mem_wdata, wd);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat,                   elat);
    chk({tag, " err"},     {30'd0, resp_err},     {30'd0, eerr});
    chk({tag, " rdata"},   resp_rdata,            erd);
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    chk({tag, " resp_valid drop"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

  initial begin
    int hold_rd;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset resp_err",   {30'd0, resp_err}, 32'd0);
    chk("reset req_ready",  {31'd0, req_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // word store / load
    do_req("SW 0x40", 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 2'b00, 32'h0);
    do_req("LW 0x40", 1'b0, 3'b010, 32'h40, 32'h0,        2'b00, 32'hDEADBEEF);

    // byte store and signed/unsigned byte loads
    do_req("SB 0x43",  1'b1, 3'b000, 32'h43, 32'h80, 2'b00, 32'h0);
    do_req("LB 0x43",  1'b0, 3'b000, 32'h43, 32'h0,  2'b00, 32'hFFFFFF80);
    do_req("LBU 0x43", 1'b0, 3'b100, 32'h43, 32'h0,  2'b00, 32'h00000080);

    // halfword and misalignment
    do_req("SH 0x12",  1'b1, 3'b001, 32'h12, 32'h8001,     2'b00, 32'h0);
    do_req("LH 0x12",  1'b0, 3'b001, 32'h12, 32'h0,        2'b00, 32'hFFFF8001);
    do_req("LHU 0x12", 1'b0, 3'b101, 32'h12, 32'h0,        2'b00, 32'h00008001);
    do_req("LW 0x41",  1'b0, 3'b010, 32'h41, 32'h0,        2'b01, 32'h0);
    do_req("SW 0x42",  1'b1, 3'b010, 32'h42, 32'h12345678, 2'b01, 32'h0);
    do_req("SH 0x13",  1'b1, 3'b001, 32'h13, 32'h5555,     2'b01, 32'h0);
    do_req("LW 0x40 unchanged", 1'b0, 3'b010, 32'h40, 32'h0, 2'b00, 32'h80ADBEEF);

    // range and funct3 faults, including priority
    do_req("LW 0x800",      1'b0, 3'b010, 32'h800,  32'h0, 2'b10, 32'h0);
    do_req("SB 0x7FF",      1'b1, 3'b000, 32'h7FF,  32'hA5, 2'b00, 32'h0);
    do_req("LBU 0x7FF",     1'b0, 3'b100, 32'h7FF,  32'h0, 2'b00, 32'h000000A5);
    do_req("SB 0x1000_0000",1'b1, 3'b000, 32'h1000_0000, 32'h11, 2'b10, 32'h0);
    do_req("L f3 011",      1'b0, 3'b011, 32'h40,   32'h0, 2'b11, 32'h0);
    do_req("S f3 100",      1'b1, 3'b100, 32'h40,   32'h0, 2'b11, 32'h0);
    do_req("L f3 011 @801", 1'b0, 3'b011, 32'h801,  32'h0, 2'b11, 32'h0);
    do_req("LH @801",       1'b0, 3'b001, 32'h801,  32'h0, 2'b01, 32'h0);

    // back-pressure: response held, competing store waits for the handshake
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp load valid", {31'd0, resp_valid}, 32'd1);
    chk("bp load rdata", resp_rdata, 32'h80ADBEEF);
    hold_rd = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h44; req_wdata = 32'h11223344;
    repeat (5) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h80ADBEEF || req_ready !== 1'b0 || mem_wr !== 1'b0)
        hold_rd++;
    end
    chk("bp hold stable 5 cycles", hold_rd, 0);
    chk("bp err held", {30'd0, resp_err}, 32'd0);
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    chk("bp after hs resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("bp after hs req_ready",  {31'd0, req_ready},  32'd1);
    chk("bp pending mem_wr",      {31'd0, mem_wr},     32'd1);
    chk("bp pending mem_addr",    {21'd0, mem_addr},   32'h44);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp store ack valid", {31'd0, resp_valid}, 32'd1);
    chk("bp store ack err",   {30'd0, resp_err},   32'd0);
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    do_req("LW 0x44", 1'b0, 3'b010, 32'h44, 32'h0, 2'b00, 32'h11223344);

    // reset while a load is in flight
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst mid load_wait busy", {31'd0, req_ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst async resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst async req_ready",  {31'd0, req_ready},  32'd1);
    @(negedge clk); rst_n = 1'b1;
    hold_rd = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0) hold_rd++;
    end
    chk("rst no stray response", hold_rd, 0);
    chk("rst release req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst rdata cleared",     resp_rdata, 32'd0);
    do_req("LW 0x40 post-reset", 1'b0, 3'b010, 32'h40, 32'h0, 2'b00, 32'h80ADBEEF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
